// File: rtl/alu_muldiv_ctrl.sv
// EX-stage ALU with decoded ALUOp/func, plus iterative mul/div feeding HI/LO.
// Single-cycle ops complete on the accept edge; mul/div take WIDTH+1 edges.
module alu_muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
    OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_ILL
  } op_t;

  state_t             state, state_n;
  op_t                op;
  logic [WIDTH-1:0]   alu_res;
  logic               is_md, md_signed, md_div_in;
  logic               neg_a_in, neg_b_in;
  logic [WIDTH-1:0]   abs_a, abs_b;

  // Iteration state: acc_hi/acc_lo are the product halves for mul and
  // remainder/quotient for div; opnd_b is the multiplicand or divisor.
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc_hi, acc_lo, opnd_b;
  logic               neg_a, neg_b, md_div, b_zero;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH:0]     div_rem;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // ---------------------------------------------------------------- decode
  // NOTE: every always_comb output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    op = OP_ILL;
    unique case (alu_op)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b11: op = OP_AND;
      2'b10: begin
        case (func)
          6'b100000: op = OP_ADD;
          6'b100010: op = OP_SUB;
          6'b100100: op = OP_AND;
          6'b100101: op = OP_OR;
          6'b101010: op = OP_SLT;
          6'b011000: op = OP_MULT;
          6'b011001: op = OP_MULTU;
          6'b011010: op = OP_DIV;
          6'b011011: op = OP_DIVU;
          6'b010000: op = OP_MFHI;
          6'b010010: op = OP_MFLO;
          6'b010001: op = OP_MTHI;
          6'b010011: op = OP_MTLO;
          default:   op = OP_ILL;
        endcase
      end
      default: op = OP_ILL;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      OP_MTHI: alu_res = a;
      OP_MTLO: alu_res = a;
      default: alu_res = '0;
    endcase
  end

  assign is_md     = (op == OP_MULT) || (op == OP_MULTU) ||
                     (op == OP_DIV)  || (op == OP_DIVU);
  assign md_signed = (op == OP_MULT) || (op == OP_DIV);
  assign md_div_in = (op == OP_DIV)  || (op == OP_DIVU);
  assign neg_a_in  = md_signed & a[WIDTH-1];
  assign neg_b_in  = md_signed & b[WIDTH-1];
  // The most negative value maps onto itself, which is the correct unsigned magnitude.
  assign abs_a     = neg_a_in ? -a : a;
  assign abs_b     = neg_b_in ? -b : b;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start && is_md) state_n = S_RUN;
      S_RUN:   if (cnt == CNT_W'(WIDTH-1)) state_n = S_FIX;
      S_FIX:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  assign busy = (state == S_RUN) || (state == S_FIX);

  // ---------------------------------------------------------------- step logic
  // Shift-add: add the multiplicand when the multiplier LSB is set, then shift right.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
  // Restoring divide: shift in the next dividend bit and subtract if it fits.
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_b};
  assign div_rem   = div_ge ? (div_shift - {1'b0, opnd_b}) : div_shift;

  assign prod_fix  = (neg_a ^ neg_b) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quo_fix   = b_zero ? '1 : ((neg_a ^ neg_b) ? -acc_lo : acc_lo);
  // Remainder follows the dividend's sign; with b=0 this recovers a itself.
  assign rem_fix   = neg_a ? -acc_hi : acc_hi;

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result  <= '0;
      zero    <= 1'b1;
      done    <= 1'b0;
      illegal <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opnd_b  <= '0;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      md_div  <= 1'b0;
      b_zero  <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (is_md) begin
              cnt    <= '0;
              acc_hi <= '0;
              acc_lo <= abs_a;
              opnd_b <= abs_b;
              neg_a  <= neg_a_in;
              neg_b  <= neg_b_in;
              md_div <= md_div_in;
              b_zero <= (b == '0);
            end else begin
              result  <= alu_res;
              zero    <= (alu_res == '0);
              done    <= 1'b1;
              illegal <= (op == OP_ILL);
              if (op == OP_MTHI) hi <= a;
              if (op == OP_MTLO) lo <= a;
            end
          end
        end
        S_RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (md_div) begin
            acc_hi <= div_rem[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          done <= 1'b1;
          if (md_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
